// File: rtl/remote_link_arbiter_if.sv
// Requester handshake plus command/response byte-FIFO link, shared by remote_link_arbiter.
// The slave modport is the arbiter's view; master is the requesters/FIFOs side.
interface remote_link_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [64*NREQ-1:0] req_addr;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [63:0]        rsp_data;
    logic               rsp_err;
    logic               full;
    logic               wr_en;
    logic [7:0]         din;
    logic               empty;
    logic               rd_en;
    logic [7:0]         dout;

    modport slave (
        input  req_valid, req_addr, rsp_ready, full, empty, dout,
        output req_ready, rsp_valid, rsp_data, rsp_err, wr_en, din, rd_en
    );

    modport master (
        output req_valid, req_addr, rsp_ready, full, empty, dout,
        input  req_ready, rsp_valid, rsp_data, rsp_err, wr_en, din, rd_en
    );
endinterface

// File: rtl/remote_link_arbiter.sv
// Round-robin arbiter/sequencer sharing one remote-ROM byte link: 8 address bytes out,
// 8 response bytes in (both LSB-first), one transaction outstanding, optional RECV timeout.
module remote_link_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    remote_link_arbiter_if.slave link
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 2);
    localparam logic [GW-1:0] LAST_INIT = GW'(NREQ - 1);
    localparam logic [TW-1:0] TIMER_LIM = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SEND, RECV, RESP} state_t;
    state_t state, state_nxt;

    logic [GW-1:0] last_grant, grant, winner;
    logic          win_found;
    logic [63:0]   addr_sr, data_sr;
    logic [2:0]    send_cnt;
    logic [3:0]    issue_cnt, got_cnt;
    logic [TW-1:0] timer;
    logic          rd_q, err_q;
    logic          grant_fire, write_fire, read_fire;
    logic          last_byte, timeout_hit, rsp_done;

    // Round-robin scan starting just past the previous winner.
    always_comb begin
        int idx;
        idx       = 0;
        winner    = '0;
        win_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (!win_found && link.req_valid[idx]) begin
                winner    = GW'(idx);
                win_found = 1'b1;
            end
        end
    end

    // Timer counts idle RECV cycles; the TIMEOUT-th idle cycle ends the wait.
    assign last_byte   = rd_q && (got_cnt == 4'd7);
    assign timeout_hit = (TIMEOUT != 0) && !rd_q && (timer == TIMER_LIM);
    assign rsp_done    = link.rsp_ready[grant];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        grant_fire = 1'b0;
        write_fire = 1'b0;
        read_fire  = 1'b0;
        case (state)
            IDLE: begin
                grant_fire = win_found;
                read_fire  = !link.empty;
                if (win_found) state_nxt = SEND;
            end
            SEND: begin
                write_fire = !link.full;
                read_fire  = !link.empty;
                if (!link.full && send_cnt == 3'd7) state_nxt = RECV;
            end
            RECV: begin
                read_fire = !link.empty && (issue_cnt < 4'd8);
                if (last_byte || timeout_hit) state_nxt = RESP;
            end
            RESP: begin
                if (rsp_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Combinational strobes are gated by rst_n so they drop the instant reset asserts.
    assign link.req_ready = (rst_n && grant_fire) ? (NREQ'(1) << winner) : '0;
    assign link.rsp_valid = (rst_n && state == RESP) ? (NREQ'(1) << grant) : '0;
    assign link.wr_en     = rst_n && write_fire;
    assign link.rd_en     = rst_n && read_fire;
    assign link.din       = addr_sr[7:0];
    assign link.rsp_data  = data_sr;
    assign link.rsp_err   = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= LAST_INIT;
            grant      <= '0;
            addr_sr    <= '0;
            data_sr    <= '0;
            send_cnt   <= '0;
            issue_cnt  <= '0;
            got_cnt    <= '0;
            timer      <= '0;
            rd_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // Only reads issued in RECV carry payload; drain reads are never captured.
            rd_q <= (state == RECV) && read_fire;
            case (state)
                IDLE: begin
                    if (grant_fire) begin
                        grant    <= winner;
                        addr_sr  <= link.req_addr[64*int'(winner) +: 64];
                        send_cnt <= '0;
                    end
                end
                SEND: begin
                    if (write_fire) begin
                        addr_sr  <= {8'h00, addr_sr[63:8]};
                        send_cnt <= send_cnt + 3'd1;
                        if (send_cnt == 3'd7) begin
                            issue_cnt <= '0;
                            got_cnt   <= '0;
                            timer     <= '0;
                        end
                    end
                end
                RECV: begin
                    if (read_fire) issue_cnt <= issue_cnt + 4'd1;
                    if (rd_q) begin
                        data_sr <= {link.dout, data_sr[63:8]};
                        got_cnt <= got_cnt + 4'd1;
                        timer   <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                    if (last_byte)        err_q <= 1'b0;
                    else if (timeout_hit) err_q <= 1'b1;
                end
                RESP: begin
                    if (rsp_done) begin
                        last_grant <= grant;
                        err_q      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
